io_uart: RTL and testbench

Memory-mapped 8N1 UART on the core's byte-wide I/O register bus, alongside `qspi` as a second consumer of the `io_write`/`io_addr`/`io_data` path in `vc`. The top level decodes `io_addr[7:4]==1` into this block's `reg_write`/`reg_read`. It buffers transmit and receive bytes in small FIFOs, generates the bit clock from a programmable divider and raises a level interrupt for the future `interrupt` input of `execute`.

---
 rtl/io_pkg.sv | 43 ++++
 rtl/io_fifo.sv | 74 +++++++
 rtl/io_uart.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_io_uart.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared definitions for the I/O register-bus peripherals.
//               It holds the UART register addresses, the STATUS and CTRL
//               bit positions, and the serial FSM state type that the TX
//               and RX engines share.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

    // UART register addresses (reg_addr[3:0])
    localparam logic [3:0] UART_TXDATA = 4'd0;
    localparam logic [3:0] UART_RXDATA = 4'd1;
    localparam logic [3:0] UART_STATUS = 4'd2;
    localparam logic [3:0] UART_DIVLO  = 4'd3;
    localparam logic [3:0] UART_DIVHI  = 4'd4;
    localparam logic [3:0] UART_CTRL   = 4'd5;

    // STATUS bit positions
    localparam int c_stat_tx_full   = 0;
    localparam int c_stat_tx_empty  = 1;
    localparam int c_stat_rx_valid  = 2;
    localparam int c_stat_rx_full   = 3;
    localparam int c_stat_overrun   = 4;
    localparam int c_stat_frame_err = 5;
    localparam int c_stat_tx_busy   = 6;

    // CTRL bit positions
    localparam int c_ctrl_rx_irq_en  = 0;
    localparam int c_ctrl_tx_irq_en  = 1;
    localparam int c_ctrl_err_irq_en = 2;

    // Serial frame state, shared by the TX and RX engines
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Small synchronous FIFO with first-word-fall-through head.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle. A pop from an empty FIFO is ignored.
// Ports       : clk, reset (async, active-low)
//               push/din  - write request and data
//               pop       - remove the head entry
//               full/empty/count - occupancy; head - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int              AW           = $clog2(DEPTH);
    localparam logic [AW:0]     c_full_count = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full_count);
    assign count     = r_count;
    assign head      = r_mem[r_rptr];
    assign w_do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_uart.sv
`default_nettype none
// ============================================================================
// Module      : io_uart
// Description : Memory-mapped 8N1 UART with TX/RX FIFOs, a programmable bit
//               divider (bit period = DIV+1 clocks) and a registered level
//               interrupt.
// Ports       : clk, reset (async, active-low)
//               reg_addr/reg_data/reg_write/reg_read - byte register bus
//               reg_rdata - combinational read data for reg_addr
//               rx (async serial in), tx (serial out), irq (level)
// Revision    : 1.0 - initial release
// ============================================================================
module io_uart
    import io_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd103,
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       reg_write,
    input  logic       reg_read,
    output logic [7:0] reg_rdata,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);

    // ---------------------------------------------------------------- regs
    logic [15:0] r_div;
    logic [2:0]  r_ctrl;
    logic        r_overrun;
    logic        r_frame_err;
    logic        r_irq;

    logic w_wr_tx;
    logic w_rd_rx;
    logic w_wr_stat;

    assign w_wr_tx   = reg_write & (reg_addr == UART_TXDATA);
    assign w_rd_rx   = reg_read  & (reg_addr == UART_RXDATA);
    assign w_wr_stat = reg_write & (reg_addr == UART_STATUS);

    // --------------------------------------------------------------- FIFOs
    logic                        w_tx_pop;
    logic                        w_txf_full;
    logic                        w_txf_empty;
    logic [$clog2(TX_DEPTH):0]   w_txf_count;
    logic [7:0]                  w_txf_head;

    logic                        w_rx_push;
    logic                        w_rxf_full;
    logic                        w_rxf_empty;
    logic [$clog2(RX_DEPTH):0]   w_rxf_count;
    logic [7:0]                  w_rxf_head;
    logic [7:0]                  r_rx_shift;

    io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_wr_tx),
        .din   (reg_data),
        .pop   (w_tx_pop),
        .full  (w_txf_full),
        .empty (w_txf_empty),
        .count (w_txf_count),
        .head  (w_txf_head)
    );

    io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rx_push),
        .din   (r_rx_shift),
        .pop   (w_rd_rx),
        .full  (w_rxf_full),
        .empty (w_rxf_empty),
        .count (w_rxf_count),
        .head  (w_rxf_head)
    );

    // ----------------------------------------------------------- TX engine
    uart_state_e r_tx_state, w_tx_state_next;
    logic [15:0] r_tx_cnt,   w_tx_cnt_next;
    logic [7:0]  r_tx_shift, w_tx_shift_next;
    logic [2:0]  r_tx_bit,   w_tx_bit_next;
    logic        r_tx,       w_tx_next;
    logic        w_tx_expire;

    assign w_tx_expire = (r_tx_cnt == 16'd0);

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_shift_next = r_tx_shift;
        w_tx_bit_next   = r_tx_bit;
        w_tx_next       = r_tx;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (!w_txf_empty) begin
                    w_tx_pop        = 1'b1;
                    w_tx_shift_next = w_txf_head;
                    w_tx_cnt_next   = r_div;
                    w_tx_state_next = ST_START;
                    w_tx_next       = 1'b0;
                end
            end
            ST_START: begin
                if (w_tx_expire) begin
                    w_tx_state_next = ST_DATA;
                    w_tx_cnt_next   = r_div;
                    w_tx_bit_next   = 3'd0;
                    w_tx_next       = r_tx_shift[0];
                end else begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (w_tx_expire) begin
                    w_tx_cnt_next = r_div;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_next = ST_STOP;
                        w_tx_next       = 1'b1;
                    end else begin
                        // tx is registered, so present the bit that will
                        // sit at shifter[0] after this shift.
                        w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                        w_tx_bit_next   = r_tx_bit + 3'd1;
                        w_tx_next       = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (w_tx_expire) begin
                    if (!w_txf_empty) begin
                        // Chain straight into the next frame, no idle gap.
                        w_tx_pop        = 1'b1;
                        w_tx_shift_next = w_txf_head;
                        w_tx_cnt_next   = r_div;
                        w_tx_state_next = ST_START;
                        w_tx_next       = 1'b0;
                    end else begin
                        w_tx_state_next = ST_IDLE;
                        w_tx_next       = 1'b1;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt - 16'd1;
                end
            end
            default: begin
                w_tx_state_next = ST_IDLE;
                w_tx_next       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_shift <= 8'd0;
            r_tx_bit   <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx       <= w_tx_next;
        end
    end

    assign tx = r_tx;

    // ----------------------------------------------------------- RX engine
    logic        r_rx_s1, r_rx_s2, r_rx_s3;
    uart_state_e r_rx_state, w_rx_state_next;
    logic [15:0] r_rx_cnt,   w_rx_cnt_next;
    logic [7:0]  w_rx_shift_next;
    logic [2:0]  r_rx_bit,   w_rx_bit_next;
    logic        w_rx_fall;
    logic        w_rx_expire;
    logic        w_frame_set;
    logic        w_overrun_set;

    assign w_rx_fall   = r_rx_s3 & ~r_rx_s2;
    assign w_rx_expire = (r_rx_cnt == 16'd0);
    // A full FIFO only loses the byte if the host is not popping this cycle.
    assign w_overrun_set = w_rx_push & w_rxf_full & ~w_rd_rx;

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_shift_next = r_rx_shift;
        w_rx_bit_next   = r_rx_bit;
        w_rx_push       = 1'b0;
        w_frame_set     = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (w_rx_fall) begin
                    // Half a bit period lands the start sample mid-bit.
                    w_rx_cnt_next   = r_div >> 1;
                    w_rx_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_rx_expire) begin
                    if (r_rx_s2) begin
                        w_rx_state_next = ST_IDLE;
                    end else begin
                        w_rx_cnt_next   = r_div;
                        w_rx_bit_next   = 3'd0;
                        w_rx_state_next = ST_DATA;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (w_rx_expire) begin
                    w_rx_shift_next = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_next   = r_div;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_next = ST_STOP;
                    end else begin
                        w_rx_bit_next = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (w_rx_expire) begin
                    w_rx_state_next = ST_IDLE;
                    if (r_rx_s2) begin
                        w_rx_push = 1'b1;
                    end else begin
                        w_frame_set = 1'b1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end
            end
            default: w_rx_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_shift <= 8'd0;
            r_rx_bit   <= 3'd0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_bit   <= w_rx_bit_next;
        end
    end

    // ------------------------------------------------- status / registers
    logic       w_tx_busy;
    logic       w_rx_valid;
    logic [7:0] w_status;
    logic       w_irq_next;

    assign w_tx_busy  = (w_txf_count != '0) | (r_tx_state != ST_IDLE);
    assign w_rx_valid = (w_rxf_count != '0);

    always_comb begin
        w_status                   = 8'h00;
        w_status[c_stat_tx_full]   = w_txf_full;
        w_status[c_stat_tx_empty]  = w_txf_empty;
        w_status[c_stat_rx_valid]  = w_rx_valid;
        w_status[c_stat_rx_full]   = w_rxf_full;
        w_status[c_stat_overrun]   = r_overrun;
        w_status[c_stat_frame_err] = r_frame_err;
        w_status[c_stat_tx_busy]   = w_tx_busy;
    end

    assign w_irq_next = (r_ctrl[c_ctrl_rx_irq_en]  & w_rx_valid)
                      | (r_ctrl[c_ctrl_tx_irq_en]  & w_txf_empty)
                      | (r_ctrl[c_ctrl_err_irq_en] & (r_overrun | r_frame_err));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div       <= DIV_RESET;
            r_ctrl      <= 3'd0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (reg_write) begin
                case (reg_addr)
                    UART_DIVLO: r_div[7:0]  <= reg_data;
                    UART_DIVHI: r_div[15:8] <= reg_data;
                    UART_CTRL:  r_ctrl      <= reg_data[2:0];
                    default:    ;
                endcase
            end
            // A new error event wins over a simultaneous write-1-to-clear.
            r_overrun   <= w_overrun_set |
                           (r_overrun & ~(w_wr_stat & reg_data[c_stat_overrun]));
            r_frame_err <= w_frame_set |
                           (r_frame_err & ~(w_wr_stat & reg_data[c_stat_frame_err]));
            r_irq       <= w_irq_next;
        end
    end

    assign irq = r_irq;

    always_comb begin
        reg_rdata = 8'h00;
        case (reg_addr)
            UART_RXDATA: reg_rdata = w_rxf_empty ? 8'h00 : w_rxf_head;
            UART_STATUS: reg_rdata = w_status;
            UART_DIVLO:  reg_rdata = r_div[7:0];
            UART_DIVHI:  reg_rdata = r_div[15:8];
            UART_CTRL:   reg_rdata = {5'b00000, r_ctrl};
            default:     reg_rdata = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_io_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_uart
// Description : Self-checking bench for io_uart: register table, serial TX
//               stream model, RX FIFO/overrun model, error and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart;
    import io_pkg::*;

    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;
    logic       rx;
    logic       tx;
    logic       irq;

    io_uart #(.DIV_RESET(16'd103), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .reg_rdata (reg_rdata),
        .rx        (rx),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // All bus tasks start and end on a falling clock edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_data  = d;
        reg_write = 1'b1;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
        @(negedge clk);
    endtask

    task automatic rd_pop(output logic [7:0] d);
        reg_addr = UART_RXDATA;
        reg_read = 1'b1;
        #1;
        d = reg_rdata;
        @(negedge clk);
        reg_read = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stopb, input int bitclk);
        rx = 1'b0;
        repeat (bitclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitclk) @(negedge clk);
        end
        rx = stopb;
        repeat (bitclk) @(negedge clk);
        rx = 1'b1;
    endtask

    // Serial line capture, one sample per falling edge while enabled.
    logic cap = 1'b0;
    logic cap_q[$];
    always @(negedge clk) if (cap) cap_q.push_back(tx);

    logic [7:0] tx_bytes [8];

    // Model: the line is one idle sample, then every accepted byte as a
    // contiguous 10-bit frame of (div+1) samples per bit, then idle.
    task automatic tx_stream(input int div, input int nwr, input string tag);
        logic exp_q[$];
        int   nexp;
        logic v;
        wr(UART_DIVLO, div[7:0]);
        wr(UART_DIVHI, div[15:8]);
        cap_q.delete();
        #1 cap = 1'b1;
        for (int i = 0; i < nwr; i++) wr(UART_TXDATA, tx_bytes[i]);
        nexp = (nwr > TX_DEPTH + 1) ? TX_DEPTH + 1 : nwr;
        exp_q.push_back(1'b1);
        for (int k = 0; k < nexp; k++) begin
            for (int b = 0; b < 10; b++) begin
                v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_bytes[k][b-1];
                repeat (div + 1) exp_q.push_back(v);
            end
        end
        repeat (3) exp_q.push_back(1'b1);
        for (int g = 0; g < 20000 && cap_q.size() < exp_q.size(); g++) @(negedge clk);
        #1 cap = 1'b0;
        check({tag, "_len"}, (cap_q.size() >= exp_q.size()), 1);
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check(tag, cap_q[i], exp_q[i]);
        @(negedge clk);
    endtask

    typedef struct {
        bit         is_wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t   tbl [19];
    logic [7:0] d;
    logic [7:0] exp_frame [10];
    logic [7:0] rx_model[$];
    bit         exp_ovr;
    int         nfr;
    bit         seen;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, UART_STATUS, 8'h00, 8'h02};
        tbl[1]  = '{1'b0, UART_DIVLO,  8'h00, 8'h67};
        tbl[2]  = '{1'b0, UART_DIVHI,  8'h00, 8'h00};
        tbl[3]  = '{1'b0, UART_CTRL,   8'h00, 8'h00};
        tbl[4]  = '{1'b0, UART_RXDATA, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, UART_TXDATA, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, 4'd9,        8'h00, 8'h00};
        tbl[7]  = '{1'b1, UART_DIVLO,  8'h34, 8'h00};
        tbl[8]  = '{1'b0, UART_DIVLO,  8'h00, 8'h34};
        tbl[9]  = '{1'b1, UART_DIVHI,  8'h12, 8'h00};
        tbl[10] = '{1'b0, UART_DIVHI,  8'h00, 8'h12};
        tbl[11] = '{1'b1, UART_CTRL,   8'hFF, 8'h00};
        tbl[12] = '{1'b0, UART_CTRL,   8'h00, 8'h07};
        tbl[13] = '{1'b1, 4'd15,       8'hFF, 8'h00};
        tbl[14] = '{1'b0, 4'd15,       8'h00, 8'h00};
        tbl[15] = '{1'b1, UART_STATUS, 8'hFF, 8'h00};
        tbl[16] = '{1'b0, UART_STATUS, 8'h00, 8'h02};
        tbl[17] = '{1'b1, UART_CTRL,   8'h00, 8'h00};
        tbl[18] = '{1'b0, UART_CTRL,   8'h00, 8'h00};

        reset = 1'b0; rx = 1'b1; reg_addr = 4'd0; reg_data = 8'd0;
        reg_write = 1'b0; reg_read = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_irq", irq, 0);
        reset = 1'b1;
        @(negedge clk);

        // ---- register table
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
            else begin
                rd(tbl[i].addr, d);
                check($sformatf("reg_tbl[%0d]", i), d, tbl[i].exp);
            end
        end

        // ---- irq lags CTRL by one clock
        repeat (2) @(negedge clk);
        check("irq_idle", irq, 0);
        wr(UART_CTRL, 8'h02);
        check("irq_lag", irq, 0);
        @(negedge clk);
        check("irq_tx_empty", irq, 1);
        wr(UART_CTRL, 8'h00);
        check("irq_hold", irq, 1);
        @(negedge clk);
        check("irq_clear", irq, 0);

        // ---- single 0xA5 frame at DIV=3 with tx_busy
        wr(UART_DIVLO, 8'd3);
        wr(UART_DIVHI, 8'd0);
        wr(UART_TXDATA, 8'hA5);
        exp_frame[0] = 8'd0;
        for (int b = 0; b < 8; b++) begin
            d = 8'hA5;
            exp_frame[b+1] = {7'd0, d[b]};
        end
        exp_frame[9] = 8'd1;
        reg_addr = UART_STATUS;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            #1;
            if (i < 40) begin
                check("a5_tx", tx, exp_frame[i/4][0]);
                check("a5_busy", reg_rdata[6], 1);
            end else begin
                check("a5_tx_idle", tx, 1);
                check("a5_busy_clear", reg_rdata[6], 0);
            end
        end
        @(negedge clk);

        // ---- back-to-back bursts: 5 accepted, 6th dropped
        for (int i = 0; i < 6; i++) tx_bytes[i] = 8'h30 + 8'(i * 17);
        tx_stream(3, 5, "burst5");
        tx_stream(3, 6, "burst6_drop");

        // ---- randomized TX streams
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
            tx_stream($urandom_range(1, 4), $urandom_range(1, 5), "tx_rand");
        end

        // ---- RX single byte at DIV=7
        wr(UART_DIVLO, 8'd7);
        wr(UART_DIVHI, 8'd0);
        rx_frame(8'h3C, 1'b1, 8);
        repeat (2) @(negedge clk);
        rd(UART_STATUS, d);
        check("rx_valid_set", d[2], 1);
        rd_pop(d);
        check("rx_data_3c", d, 8'h3C);
        rd(UART_STATUS, d);
        check("rx_valid_clr", d[2], 0);
        rd(UART_RXDATA, d);
        check("rx_empty_read", d, 8'h00);

        // ---- RX bursts against a queue model of the FIFO
        for (int r = 0; r < 3; r++) begin
            nfr = (r == 0) ? 5 : $urandom_range(1, 6);
            rx_model.delete();
            exp_ovr = 1'b0;
            for (int f = 0; f < nfr; f++) begin
                d = 8'($urandom);
                if (rx_model.size() < RX_DEPTH) rx_model.push_back(d);
                else exp_ovr = 1'b1;
                rx_frame(d, 1'b1, 8);
                repeat (2) @(negedge clk);
            end
            rd(UART_STATUS, d);
            check("rx_burst_status", d,
                  {3'b000, exp_ovr, (rx_model.size() == RX_DEPTH), 1'b1, 2'b10});
            while (rx_model.size() > 0) begin
                rd_pop(d);
                check("rx_burst_data", d, rx_model.pop_front());
            end
            rd(UART_STATUS, d);
            check("rx_burst_drained", d, {3'b000, exp_ovr, 4'b0010});
            wr(UART_STATUS, 8'h10);
            rd(UART_STATUS, d);
            check("ovr_w1c", d, 8'h02);
        end

        // ---- framing error, irq one clock after the flag
        wr(UART_CTRL, 8'h04);
        repeat (2) @(negedge clk);
        check("fe_irq_pre", irq, 0);
        reg_addr = UART_STATUS;
        seen = 1'b0;
        fork
            rx_frame(8'h55, 1'b0, 8);
            begin
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    #1;
                    if (reg_rdata[5]) begin
                        seen = 1'b1;
                        check("fe_irq_lag", irq, 0);
                        @(negedge clk);
                        #1;
                        check("fe_irq_rise", irq, 1);
                    end
                end
            end
        join
        check("fe_seen", seen, 1);
        @(negedge clk);
        rd(UART_STATUS, d);
        check("fe_status", d, 8'h22);
        wr(UART_STATUS, 8'h20);
        check("fe_irq_hold", irq, 1);
        @(negedge clk);
        check("fe_irq_drop", irq, 0);
        rd(UART_STATUS, d);
        check("fe_cleared", d, 8'h02);
        wr(UART_CTRL, 8'h00);

        // ---- 2-clock glitch is rejected, next frame still received
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        rd(UART_STATUS, d);
        check("glitch_status", d, 8'h02);
        rx_frame(8'h81, 1'b1, 8);
        repeat (2) @(negedge clk);
        rd_pop(d);
        check("glitch_next_frame", d, 8'h81);

        // ---- reset mid-frame
        wr(UART_DIVLO, 8'd3);
        wr(UART_DIVHI, 8'd0);
        wr(UART_TXDATA, 8'h11);
        wr(UART_TXDATA, 8'h22);
        check("rst_pre_start", tx, 0);
        #2 reset = 1'b0;
        #1 check("rst_tx_async", tx, 1);
        rd(UART_STATUS, d);
        check("rst_status", d, 8'h02);
        rd(UART_DIVLO, d);
        check("rst_div", d, 8'h67);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_tx_stays", tx, 1);
        rd(UART_STATUS, d);
        check("rst_fifo_empty", d, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
